muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
Execute-stage controller that sequences the iterative shift-add multiplier for MULTU and owns the architectural HI/LO registers. It accepts HI/LO-class instructions from EX and launches the multiplier with a start pulse. It interlocks the pipeline while a product is pending, then commits the 64-bit product to HI/LO and serves MFHI/MFLO/MTHI/MTLO.

Parameters:
TIMEOUT, 40, max cycles in WAIT before abort (> multiplier latency of 33)
CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
ex_valid  input  1  EX holds a valid instruction this cycle
ex_funct  input  6  R-type funct of EX instruction
ex_rs_data  input  32  rs operand (multiplicand / MTHI/MTLO source)
ex_rt_data  input  32  rt operand (multiplier)
stall  output  1  combinational; freeze IF/ID/EX, EX inputs held stable
hilo_rdata  output  32  MFHI/MFLO result, combinational
mul_start  output  1  one-cycle start pulse to multiplier
mul_a  output  32  registered multiplicand to multiplier
mul_b  output  32  registered multiplier operand
mul_done  input  1  multiplier result valid (sampled in WAIT only)
mul_product  input  64  multiplier result
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  state != IDLE
err  output  1  sticky timeout flag

Behaviour:
- Reset: always uses the synchronous, active-high reset on clk. state=IDLE; hi, lo, mul_a, mul_b = 0; mul_start=0; err=0; counter=0. Reset has priority over every other event, including mid-WAIT: the multiply is abandoned and no HI/LO write occurs. The external multiplier shares the same reset.
- Decoded functs (only when ex_valid=1): MULTU 011001, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. HI/LO-class = any of these five. All other functs are ignored and never stall.
- stall = ex_valid & HI/LO-class & (state != IDLE). Asserted combinationally in the same cycle.
- States:
  - IDLE:
    - MULTU: mul_a<=rs, mul_b<=rt, go START. MULTU itself does not stall.
    - MTHI/MTLO: hi<=rs or lo<=rs at the edge.
    - MFHI/MFLO: hilo_rdata = hi or lo this cycle.
  - START: mul_start=1 for exactly this cycle; counter<=0; go WAIT.
  - WAIT:
    - mul_done=1: hi<=mul_product[63:32], lo<=mul_product[31:0], go IDLE.
    - Else if counter==TIMEOUT-1: err<=1, go IDLE, hi/lo unchanged.
    - Else counter++.
- mul_done is ignored in IDLE and START.
- Latency: MULTU in EX at cycle T; mul_start high at T+1; earliest commit at the edge ending T+2. HI/LO values are visible the cycle after mul_done.
- A stalled HI/LO instruction executes in the first cycle state==IDLE, using the freshly committed HI/LO.
- hilo_rdata = 0 when the EX instruction is not MFHI/MFLO.
- Unsigned arithmetic only. The controller does no width extension; the product is taken verbatim.
- err clears only on reset. A new MULTU after a timeout is accepted normally.
- mul_a/mul_b hold their values until the next MULTU acceptance.

Test Plan:
- Reset, then idle for 5 cycles -> hi=lo=0, stall=0, busy=0, mul_start=0, err=0.
- MULTU rs=3, rt=5; bench model asserts done 33 cycles after start -> exactly one mul_start pulse with mul_a=3, mul_b=5; then hi=0, lo=15, busy drops.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULTU 7x6 immediately followed by MFLO held in EX -> stall=1 every cycle until commit; in the first IDLE cycle stall=0 and hilo_rdata=42. Also: a second MULTU issued while busy stalls the same way.
- MTHI rs=0xDEADBEEF, next cycle MFHI -> hilo_rdata=0xDEADBEEF. A non-HI/LO funct (e.g. 100001) issued while busy -> stall=0.
- Timeout: model never asserts done -> err=1 after TIMEOUT cycles in WAIT, hi/lo unchanged, busy=0. Separately, assert reset mid-WAIT -> next cycle state IDLE, hi/lo=0, err=0, and a late done is ignored.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: execute-stage controller for MULTU and the HI/LO registers.
// It launches the external iterative multiplier and interlocks the pipeline
// while a product is pending. It commits the 64-bit result into HI/LO and
// serves MFHI/MFLO/MTHI/MTLO.
module muldiv_hilo_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        err
);

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic             mul_start_q, mul_start_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic isMultu;
  logic isMfhi;
  logic isMthi;
  logic isMflo;
  logic isMtlo;
  logic isHiloClass;
  logic isIdle;

  // Decode the EX instruction; only a valid instruction counts as HI/LO-class.
  always_comb begin
    isMultu     = ex_valid && (ex_funct == FN_MULTU);
    isMfhi      = ex_valid && (ex_funct == FN_MFHI);
    isMthi      = ex_valid && (ex_funct == FN_MTHI);
    isMflo      = ex_valid && (ex_funct == FN_MFLO);
    isMtlo      = ex_valid && (ex_funct == FN_MTLO);
    isHiloClass = isMultu || isMfhi || isMthi || isMflo || isMtlo;
    isIdle      = (state_q == ST_IDLE);
  end

  // Interlock and read port. A stalled MFHI/MFLO is re-presented once the
  // controller is idle, so its read sees the freshly committed HI/LO.
  always_comb begin
    stall      = isHiloClass && !isIdle;
    hilo_rdata = 32'd0;
    if (isMfhi) begin
      hilo_rdata = hi_q;
    end else if (isMflo) begin
      hilo_rdata = lo_q;
    end
  end

  // Next-state logic. HI/LO instructions take effect only in IDLE. mul_start
  // is set on the way into START, so its registered copy is high for exactly
  // the START cycle.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (isMultu) begin
          mul_a_d     = ex_rs_data;
          mul_b_d     = ex_rt_data;
          mul_start_d = 1'b1;
          state_d     = ST_START;
        end else if (isMthi) begin
          hi_d = ex_rs_data;
        end else if (isMtlo) begin
          lo_d = ex_rs_data;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done) begin
          hi_d    = mul_product[63:32];
          lo_d    = mul_product[31:0];
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Synchronous reset abandons any multiply in flight without
  // touching HI/LO beyond clearing them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      mul_a_q     <= 32'd0;
      mul_b_q     <= 32'd0;
      mul_start_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Drive the outputs from the registered state.
  always_comb begin
    mul_start = mul_start_q;
    mul_a     = mul_a_q;
    mul_b     = mul_b_q;
    hi        = hi_q;
    lo        = lo_q;
    busy      = !isIdle;
    err       = err_q;
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: self-checking bench for muldiv_hilo_ctrl.
// It uses a behavioural multiplier that raises done a programmable number of
// cycles after start. It also keeps an arithmetic HI/LO reference model.
module tb_muldiv_hilo_ctrl;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;

  logic        clk = 1'b0;
  logic        reset;
  logic        exValid;
  logic [5:0]  exFunct;
  logic [31:0] exRs;
  logic [31:0] exRt;
  logic        stall;
  logic [31:0] hiloRdata;
  logic        mulStart;
  logic [31:0] mulA;
  logic [31:0] mulB;
  logic        mulDone;
  logic [63:0] mulProduct;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] refHi;
  logic [31:0] refLo;

  bit modelEnable = 1'b1;
  bit neverDone   = 1'b0;
  int doneDelay   = 33;
  int remaining   = 0;
  int startCount  = 0;

  muldiv_hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (exValid),
    .ex_funct    (exFunct),
    .ex_rs_data  (exRs),
    .ex_rt_data  (exRt),
    .stall       (stall),
    .hilo_rdata  (hiloRdata),
    .mul_start   (mulStart),
    .mul_a       (mulA),
    .mul_b       (mulB),
    .mul_done    (mulDone),
    .mul_product (mulProduct),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .err         (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural multiplier: done is raised doneDelay cycles after the start pulse.
  initial begin
    mulDone    = 1'b0;
    mulProduct = 64'd0;
    forever begin
      @(negedge clk);
      if (modelEnable) begin
        if (reset) begin
          remaining = 0;
          mulDone   = 1'b0;
        end else begin
          if (mulDone) mulDone = 1'b0;
          if (mulStart) begin
            startCount++;
            mulProduct = {32'd0, mulA} * {32'd0, mulB};
            remaining  = neverDone ? 0 : doneDelay;
          end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) mulDone = 1'b1;
          end
        end
      end
    end
  end

  // Global safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    reset   = 1'b1;
    exValid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    refHi = 32'd0;
    refLo = 32'd0;
    repeat (5) @(negedge clk);
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mulStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_start: got %b want 0", mulStart); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic runMultu(input logic [31:0] a, input logic [31:0] b, input int delay, input string name);
    int cycles;
    int startsBefore;
    logic [63:0] prod;
    doneDelay    = delay;
    startsBefore = startCount;
    exValid = 1'b1; exFunct = FN_MULTU; exRs = a; exRt = b;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL %s_issue_stall: got %b want 0", name, stall); end
    @(negedge clk);
    exValid = 1'b0; exRs = $urandom; exRt = $urandom;
    #1;
    checks++; if (mulStart !== 1'b1) begin failures++; $display("[TB] FAIL %s_start: got %b want 1", name, mulStart); end
    checks++; if (mulA !== a) begin failures++; $display("[TB] FAIL %s_mul_a: got %h want %h", name, mulA, a); end
    checks++; if (mulB !== b) begin failures++; $display("[TB] FAIL %s_mul_b: got %h want %h", name, mulB, b); end
    cycles = 1;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    prod  = {32'd0, a} * {32'd0, b};
    refHi = prod[63:32];
    refLo = prod[31:0];
    checks++; if (cycles != delay + 2) begin failures++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, cycles, delay + 2); end
    checks++; if (hi !== refHi) begin failures++; $display("[TB] FAIL %s_hi: got %h want %h", name, hi, refHi); end
    checks++; if (lo !== refLo) begin failures++; $display("[TB] FAIL %s_lo: got %h want %h", name, lo, refLo); end
    checks++; if (startCount - startsBefore != 1) begin failures++; $display("[TB] FAIL %s_pulses: got %0d want 1", name, startCount - startsBefore); end
  endtask

  task automatic test_multu_basic();
    @(negedge clk);
    runMultu(32'd3, 32'd5, 33, "multu_3x5");
  endtask

  task automatic test_multu_max();
    @(negedge clk);
    runMultu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "multu_max");
  endtask

  task automatic test_stall_mflo();
    int cycles;
    @(negedge clk);
    doneDelay = 33;
    exValid = 1'b1; exFunct = FN_MULTU; exRs = 32'd7; exRt = 32'd6;
    @(negedge clk);
    exFunct = FN_MFLO; exRs = 32'd0; exRt = 32'd0;
    #1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL mflo_stall_busy: got %b want 1 (cycle %0d)", stall, cycles); end
      @(negedge clk);
      #1;
      cycles++;
    end
    refHi = 32'd0;
    refLo = 32'd7 * 32'd6;
    checks++; if (cycles != 34) begin failures++; $display("[TB] FAIL mflo_wait_cycles: got %0d want 34", cycles); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL mflo_stall_idle: got %b want 0", stall); end
    checks++; if (hiloRdata !== refLo) begin failures++; $display("[TB] FAIL mflo_rdata: got %h want %h", hiloRdata, refLo); end
    @(negedge clk);
    exValid = 1'b0;
  endtask

  task automatic test_stall_multu();
    int cycles;
    int startsBefore;
    logic [63:0] prod;
    @(negedge clk);
    startsBefore = startCount;
    doneDelay = 10;
    exValid = 1'b1; exFunct = FN_MULTU; exRs = 32'd2; exRt = 32'd3;
    @(negedge clk);
    exRs = 32'd4; exRt = 32'd5;
    #1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL multu2_stall_busy: got %b want 1 (cycle %0d)", stall, cycles); end
      @(negedge clk);
      #1;
      cycles++;
    end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL multu2_stall_idle: got %b want 0", stall); end
    checks++; if (lo !== 32'd6) begin failures++; $display("[TB] FAIL multu2_first_lo: got %h want 6", lo); end
    @(negedge clk);
    exValid = 1'b0;
    #1;
    checks++; if (mulStart !== 1'b1) begin failures++; $display("[TB] FAIL multu2_start: got %b want 1", mulStart); end
    checks++; if (mulA !== 32'd4 || mulB !== 32'd5) begin failures++; $display("[TB] FAIL multu2_operands: got %h,%h want 4,5", mulA, mulB); end
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    prod  = {32'd0, 32'd4} * {32'd0, 32'd5};
    refHi = prod[63:32];
    refLo = prod[31:0];
    checks++; if (hi !== refHi || lo !== refLo) begin failures++; $display("[TB] FAIL multu2_hilo: got %h_%h want %h_%h", hi, lo, refHi, refLo); end
    checks++; if (startCount - startsBefore != 2) begin failures++; $display("[TB] FAIL multu2_pulses: got %0d want 2", startCount - startsBefore); end
  endtask

  task automatic test_mthi_mfhi();
    logic [31:0] v;
    @(negedge clk);
    exValid = 1'b1; exFunct = FN_MTHI; exRs = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL mthi_stall: got %b want 0", stall); end
    checks++; if (hiloRdata !== 32'd0) begin failures++; $display("[TB] FAIL mthi_rdata_zero: got %h want 0", hiloRdata); end
    refHi = 32'hDEAD_BEEF;
    @(negedge clk);
    exFunct = FN_MFHI; exRs = 32'd0;
    #1;
    checks++; if (hiloRdata !== refHi) begin failures++; $display("[TB] FAIL mfhi_rdata: got %h want %h", hiloRdata, refHi); end
    v = $urandom;
    @(negedge clk);
    exFunct = FN_MTLO; exRs = v;
    refLo = v;
    @(negedge clk);
    exFunct = FN_MFLO; exRs = 32'd0;
    #1;
    checks++; if (hiloRdata !== refLo) begin failures++; $display("[TB] FAIL mflo_after_mtlo: got %h want %h", hiloRdata, refLo); end
    @(negedge clk);
    exValid = 1'b0;
    #1;
    checks++; if (hiloRdata !== 32'd0) begin failures++; $display("[TB] FAIL rdata_invalid: got %h want 0", hiloRdata); end
    checks++; if (hi !== refHi) begin failures++; $display("[TB] FAIL mthi_hold: got %h want %h", hi, refHi); end
  endtask

  task automatic test_nonhilo_busy();
    int cycles;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    doneDelay = 15;
    exValid = 1'b1; exFunct = FN_MULTU; exRs = a; exRt = b;
    @(negedge clk);
    exFunct = FN_ADDU;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL addu_busy: got %b want 1", busy); end
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL addu_stall: got %b want 0 (cycle %0d)", stall, cycles); end
      @(negedge clk);
      #1;
      cycles++;
    end
    prod  = {32'd0, a} * {32'd0, b};
    refHi = prod[63:32];
    refLo = prod[31:0];
    checks++; if (hi !== refHi || lo !== refLo) begin failures++; $display("[TB] FAIL addu_hilo: got %h_%h want %h_%h", hi, lo, refHi, refLo); end
    exValid = 1'b0;
  endtask

  task automatic test_random();
    int op;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      op = $urandom_range(0, 4);
      d  = $urandom;
      case (op)
        0: runMultu(d, $urandom, $urandom_range(1, 38), "rand_multu");
        1: begin
          exValid = 1'b1; exFunct = FN_MTHI; exRs = d;
          @(negedge clk);
          exValid = 1'b0;
          refHi = d;
          checks++; if (hi !== refHi) begin failures++; $display("[TB] FAIL rand_mthi: got %h want %h", hi, refHi); end
        end
        2: begin
          exValid = 1'b1; exFunct = FN_MTLO; exRs = d;
          @(negedge clk);
          exValid = 1'b0;
          refLo = d;
          checks++; if (lo !== refLo) begin failures++; $display("[TB] FAIL rand_mtlo: got %h want %h", lo, refLo); end
        end
        3: begin
          exValid = 1'b1; exFunct = FN_MFHI; exRs = d;
          #1;
          checks++; if (hiloRdata !== refHi) begin failures++; $display("[TB] FAIL rand_mfhi: got %h want %h", hiloRdata, refHi); end
          @(negedge clk);
          exValid = 1'b0;
        end
        default: begin
          exValid = 1'b1; exFunct = FN_MFLO; exRs = d;
          #1;
          checks++; if (hiloRdata !== refLo) begin failures++; $display("[TB] FAIL rand_mflo: got %h want %h", hiloRdata, refLo); end
          @(negedge clk);
          exValid = 1'b0;
        end
      endcase
    end
  endtask

  task automatic test_timeout();
    int cycles;
    @(negedge clk);
    neverDone = 1'b1;
    exValid = 1'b1; exFunct = FN_MULTU; exRs = 32'h0000_1234; exRt = 32'h0000_5678;
    @(negedge clk);
    exValid = 1'b0;
    cycles = 1;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checks++; if (cycles != TIMEOUT + 2) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d want %0d", cycles, TIMEOUT + 2); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err: got %b want 1", err); end
    checks++; if (hi !== refHi || lo !== refLo) begin failures++; $display("[TB] FAIL timeout_hilo: got %h_%h want %h_%h", hi, lo, refHi, refLo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy: got %b want 0", busy); end
    neverDone = 1'b0;
    @(negedge clk);
    runMultu(32'd9, 32'd9, 20, "after_timeout");
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_midwait();
    @(negedge clk);
    doneDelay = 33;
    exValid = 1'b1; exFunct = FN_MULTU; exRs = 32'd11; exRt = 32'd13;
    @(negedge clk);
    exValid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midwait_busy: got %b want 1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    refHi = 32'd0;
    refLo = 32'd0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midwait_reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("[TB] FAIL midwait_reset_hilo: got %h_%h want 0_0", hi, lo); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL midwait_reset_err: got %b want 0", err); end
    checks++; if (mulStart !== 1'b0) begin failures++; $display("[TB] FAIL midwait_reset_start: got %b want 0", mulStart); end
    modelEnable = 1'b0;
    @(negedge clk);
    mulProduct = 64'hAAAA_BBBB_CCCC_DDDD;
    mulDone    = 1'b1;
    @(negedge clk);
    mulDone = 1'b0;
    @(negedge clk);
    checks++; if (hi !== refHi || lo !== refLo) begin failures++; $display("[TB] FAIL late_done_hilo: got %h_%h want %h_%h", hi, lo, refHi, refLo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL late_done_busy: got %b want 0", busy); end
    modelEnable = 1'b1;
  endtask

  // Test sequence.
  initial begin
    reset   = 1'b1;
    exValid = 1'b0;
    exFunct = 6'd0;
    exRs    = 32'd0;
    exRt    = 32'd0;
    refHi   = 32'd0;
    refLo   = 32'd0;
    test_reset();
    test_multu_basic();
    test_multu_max();
    test_stall_mflo();
    test_stall_multu();
    test_mthi_mfhi();
    test_nonhilo_busy();
    test_random();
    test_timeout();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
